// File: rtl/seqsum_pkg.sv
// rtl/seqsum_pkg.sv - shared types and constants for the sequential-summation scheduler
package seqsum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DW   = 32;
  localparam int DEFAULT_STEP = 2;

  // A single requester still needs a one-bit id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seqsum_rr_arb.sv
// rtl/seqsum_rr_arb.sv - round-robin arbiter, first requester at or above ptr_i with wrap
module seqsum_rr_arb
  import seqsum_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic             gnt_any_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o     = '0;
    gnt_id_o  = '0;
    gnt_any_o = 1'b0;
    found     = 1'b0;
    idx       = 0;
    if (en_i) begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = (int'(ptr_i) + i) % N_REQ;
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          gnt_id_o   = ID_W'(idx);
        end
      end
      gnt_any_o = found;
    end
  end

endmodule

// File: rtl/seqsum_sched.sv
// rtl/seqsum_sched.sv - shared summation engine with N-requester front end; SEQSUM_SCHED_OVF_EN adds rsp_ovf
module seqsum_sched
  import seqsum_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int DW    = DEFAULT_DW,
  parameter  int STEP  = DEFAULT_STEP,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DW-1:0]     rsp_sum,
  output logic [DW:0]       rsp_terms
`ifdef SEQSUM_SCHED_OVF_EN
  ,
  output logic              rsp_ovf
`endif
);

  state_t          state_q;
  logic [ID_W-1:0] rr_q;
  logic [ID_W-1:0] id_q;
  logic [DW-1:0]   a_q;
  logic [DW:0]     span_q;
  logic [DW:0]     off_q;
  logic [DW-1:0]   acc_q;
  logic [DW:0]     terms_q;
  logic            valid_q;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;
  logic [DW-1:0]    a_sel;
  logic [DW-1:0]    b_sel;
  logic [DW:0]      span_d;
  logic [DW-1:0]    term;
  logic [DW-1:0]    acc_d;
  logic [DW+1:0]    off_step;
  logic             last_term;
  logic             span_neg;

  seqsum_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_q),
    .en_i      (state_q == IDLE),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .gnt_any_o (gnt_any)
  );

  assign req_ready = gnt;
  assign a_sel     = req_a[int'(gnt_id)*DW +: DW];
  assign b_sel     = req_b[int'(gnt_id)*DW +: DW];
  // Signed span in DW+1 bits: the top bit set means a > b.
  assign span_d    = {1'b0, b_sel} - {1'b0, a_sel};
  assign span_neg  = span_q[DW];

  // off never exceeds span, so its low DW bits carry the full offset.
  assign term      = a_q + off_q[DW-1:0];
  assign off_step  = {1'b0, off_q} + (DW+2)'(STEP);
  assign last_term = off_step > {1'b0, span_q};

`ifdef SEQSUM_SCHED_OVF_EN
  logic ovf_q;
  logic carry;
  assign {carry, acc_d} = {1'b0, acc_q} + {1'b0, term};
  assign rsp_ovf        = ovf_q;
`else
  assign acc_d = acc_q + term;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      a_q     <= '0;
      span_q  <= '0;
      off_q   <= '0;
      acc_q   <= '0;
      terms_q <= '0;
      valid_q <= 1'b0;
`ifdef SEQSUM_SCHED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            id_q    <= gnt_id;
            a_q     <= a_sel;
            span_q  <= span_d;
            off_q   <= '0;
            acc_q   <= '0;
            terms_q <= '0;
            rr_q    <= (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
            state_q <= RUN;
`ifdef SEQSUM_SCHED_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (span_neg) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end else begin
            acc_q   <= acc_d;
            terms_q <= terms_q + 1'b1;
            off_q   <= off_step[DW:0];
`ifdef SEQSUM_SCHED_OVF_EN
            ovf_q   <= ovf_q | carry;
`endif
            if (last_term) begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = acc_q;
  assign rsp_terms = terms_q;

endmodule

// File: doc/seqsum_sched.md
Name: seqsum_sched

Overview:
Shared sequential-summation engine with N-requester front end. Each requester submits a job (a, b). A round-robin arbiter grants one job at a time. The engine accumulates a, a+STEP, a+2*STEP, … while the term is ≤ b, one term per clock. It returns the sum tagged with the requester id over a valid/ready response port. It sits between requesting blocks and the single summation datapath, so the datapath is never replicated.

Parameters:
N_REQ, 4, number of requesters (≥2)
DW, 32, operand/sum width (unsigned)
STEP, 2, increment between terms (≥1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  N_REQ  per-requester job valid
req_ready  output  N_REQ  per-requester accept; one-hot or zero
req_a  input  N_REQ*DW  start values, requester i at [i*DW +: DW]
req_b  input  N_REQ*DW  end values, same packing
rsp_valid  output  1  result valid
rsp_ready  input  1  result accepted
rsp_id  output  clog2(N_REQ)  requester that owns the result
rsp_sum  output  DW  sum mod 2^DW
rsp_terms  output  DW+1  number of terms added

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high. All state updates on posedge clk.
- Reset state:
  - FSM = IDLE, rr pointer = 0.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_terms = 0.
- Reset asserted mid-operation aborts the job. No response is produced for the aborted job.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Arbiter picks the first requester with req_valid, searching from rr pointer upward with wrap.
  - req_ready is high for that requester only, combinationally.
  - On handshake in cycle T: latch a, b and the grant id. Set acc = 0, off = 0 (DW+1 bits), span = b - a (DW+1 bits, signed sense; negative means a > b). Set rr = grant id + 1 mod N_REQ. Go to RUN.
- RUN, one cycle per term:
  - If a > b: no add. Go to DONE.
  - Else: acc += a + off (mod 2^DW), terms += 1, off += STEP.
  - Go to DONE when off + STEP > span. Compare in DW+1 bits so no wrap-around is possible.
  - Guarantees termination for b near 2^DW-1.
- DONE:
  - rsp_valid = 1 and outputs are held stable until rsp_ready.
  - On handshake, go to IDLE.
  - req_ready = 0 in RUN and DONE, so no new grants are made.
- Latency: for k = floor((b-a)/STEP)+1 terms (k = 0 if a > b), rsp_valid first rises at cycle T+1+max(k,1).
- Throughput: the next grant is possible in the cycle after the rsp handshake.
- req_a/req_b are sampled only at the handshake. Later changes do not affect the job.
- rsp_terms holds k.

Optional Feature:
SEQSUM_SCHED_OVF_EN
- Defined:
  - Extra output rsp_ovf (1 bit), reset 0.
  - Set if any accumulation step carried out of DW bits during the job.
  - Cleared at each new grant. Held with rsp_* in DONE.
- Undefined: port absent, no carry logic; sum still wraps mod 2^DW.

Decomposition:
- Package seqsum_pkg:
  - state enum {IDLE, RUN, DONE}
  - ID_W = clog2(N_REQ) helper
  - default DW/STEP constants
- One sub-module, seqsum_rr_arb: N_REQ round-robin arbiter.
  - Inputs: req vector, pointer, enable.
  - Output: one-hot grant plus encoded id.
- The accumulator/counter datapath stays in seqsum_sched.

Test Plan:
- Req0 a=1, b=10, rsp_ready=1 → rsp_sum=25, rsp_terms=5, rsp_id=0, rsp_valid at T+6.
- Req2 a=7, b=7 → sum=7, terms=1, valid at T+2. Then req1 a=10, b=1 → sum=0, terms=0, valid at T+2.
- Req3 a=0xFFFFFFFD, b=0xFFFFFFFF → terms=2, sum=0xFFFFFFFC, no hang. With SEQSUM_SCHED_OVF_EN, rsp_ovf=1.
- All four req_valid held high, each job a=0, b=4 → grant order 0,1,2,3,0. Each rsp_sum=6, and req_ready is never multi-hot.
- rsp_ready held low 5 cycles in DONE → rsp_valid/id/sum stable and no req_ready asserted. Releasing rsp_ready completes the handshake and returns to IDLE next cycle.
- rst pulsed during RUN of a=1, b=100 → next cycle all outputs are at reset values. A subsequent job a=2, b=6 returns 12, with rr pointer back at 0.
